// File: rtl/pcs_receive_gmii.sv
// pcs_receive_gmii: 1000BASE-X PCS receive state machine driving GMII RX_DV/RX_ER/RXD.
// Revision 1.0 - initial release.
`default_nettype none

module pcs_receive_gmii #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int CNT_W           = 16,
  parameter bit ERR_ON_CODE_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_status,
  input  logic             sudi_valid,
  input  logic             sudi_k,
  input  logic [7:0]       sudi_data,
  input  logic             sudi_err,
  output logic             RX_DV,
  output logic             RX_ER,
  output logic [7:0]       RXD,
  output logic             carrier_sense,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  localparam int BC_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [BC_W-1:0] c_MAX_BYTES = BC_W'(MAX_FRAME_BYTES);

  localparam logic [7:0] c_K28_5 = 8'hBC;
  localparam logic [7:0] c_K_S   = 8'hFB;
  localparam logic [7:0] c_K_T   = 8'hFD;
  localparam logic [7:0] c_K_R   = 8'hF7;

  localparam logic [7:0] c_RXD_SFD   = 8'h55;
  localparam logic [7:0] c_RXD_FCAR  = 8'h0E;
  localparam logic [7:0] c_RXD_CEXT  = 8'h0F;

  typedef enum logic [3:0] {
    LINK_FAILED   = 4'd0,
    WAIT_K        = 4'd1,
    RX_K          = 4'd2,
    IDLE_D        = 4'd3,
    RECEIVE       = 4'd4,
    FALSE_CARRIER = 4'd5,
    TRR           = 4'd6,
    JABBER        = 4'd7
  } state_t;

  state_t            state_q, state_d;
  logic              rx_dv_q, rx_dv_d;
  logic              rx_er_q, rx_er_d;
  logic [7:0]        rxd_q, rxd_d;
  logic              cs_q, cs_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  ok_q, err_q;
  logic              inc_ok, inc_err;
  logic              is_data, is_k28_5;

  assign is_data  = !sudi_k && !sudi_err;
  assign is_k28_5 = sudi_k && !sudi_err && (sudi_data == c_K28_5);

  always_comb begin
    state_d = state_q;
    rx_dv_d = rx_dv_q;
    rx_er_d = rx_er_q;
    rxd_d   = rxd_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    inc_ok  = 1'b0;
    inc_err = 1'b0;

    if (!sync_status) begin
      // A frame in flight when alignment is lost is closed with one error cycle.
      state_d = LINK_FAILED;
      rxd_d   = 8'h00;
      cs_d    = 1'b0;
      if (rx_dv_q && (state_q != LINK_FAILED)) begin
        rx_dv_d = 1'b1;
        rx_er_d = 1'b1;
        inc_err = 1'b1;
      end else begin
        rx_dv_d = 1'b0;
        rx_er_d = 1'b0;
      end
    end else if (sudi_valid) begin
      rx_dv_d = 1'b0;
      rx_er_d = 1'b0;
      rxd_d   = 8'h00;
      cs_d    = 1'b0;
      case (state_q)
        LINK_FAILED: state_d = WAIT_K;
        WAIT_K: begin
          if (is_k28_5) state_d = RX_K;
        end
        RX_K: begin
          state_d = is_data ? IDLE_D : WAIT_K;
        end
        IDLE_D: begin
          if (is_k28_5) begin
            state_d = RX_K;
          end else if (sudi_k && !sudi_err && (sudi_data == c_K_S)) begin
            state_d = RECEIVE;
            rx_dv_d = 1'b1;
            rxd_d   = c_RXD_SFD;
            cs_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = FALSE_CARRIER;
            rx_er_d = 1'b1;
            rxd_d   = c_RXD_FCAR;
            cs_d    = 1'b1;
          end
        end
        FALSE_CARRIER: begin
          if (is_k28_5) begin
            state_d = RX_K;
          end else begin
            rx_er_d = 1'b1;
            rxd_d   = c_RXD_FCAR;
            cs_d    = 1'b1;
          end
        end
        RECEIVE: begin
          if (sudi_err) begin
            rx_dv_d = 1'b1;
            rx_er_d = ERR_ON_CODE_ERR;
            rxd_d   = sudi_data;
            cs_d    = 1'b1;
            if (cnt_q < c_MAX_BYTES) cnt_d = cnt_q + 1'b1;
          end else if (!sudi_k) begin
            if (cnt_q >= c_MAX_BYTES) begin
              state_d = JABBER;
              rx_dv_d = 1'b1;
              rx_er_d = 1'b1;
              inc_err = 1'b1;
            end else begin
              rx_dv_d = 1'b1;
              rxd_d   = sudi_data;
              cs_d    = 1'b1;
              cnt_d   = cnt_q + 1'b1;
            end
          end else if (sudi_data == c_K_T) begin
            state_d = TRR;
            rxd_d   = c_RXD_CEXT;
            cs_d    = 1'b1;
          end else if (sudi_data == c_K28_5) begin
            state_d = RX_K;
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
            inc_err = 1'b1;
          end else begin
            // /V/ and any unexpected K character both signal a coding error.
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
            cs_d    = 1'b1;
          end
        end
        TRR: begin
          state_d = RX_K;
          rxd_d   = c_RXD_CEXT;
          if (sudi_k && !sudi_err && (sudi_data == c_K_R)) begin
            inc_ok  = 1'b1;
          end else begin
            rx_er_d = 1'b1;
            inc_err = 1'b1;
          end
        end
        JABBER: begin
          if (is_k28_5) state_d = RX_K;
        end
        default: state_d = LINK_FAILED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LINK_FAILED;
      rx_dv_q <= 1'b0;
      rx_er_q <= 1'b0;
      rxd_q   <= 8'h00;
      cs_q    <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rx_dv_q <= rx_dv_d;
      rx_er_q <= rx_er_d;
      rxd_q   <= rxd_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      if (inc_ok && (ok_q != {CNT_W{1'b1}}))   ok_q  <= ok_q + 1'b1;
      if (inc_err && (err_q != {CNT_W{1'b1}})) err_q <= err_q + 1'b1;
    end
  end

  assign RX_DV         = rx_dv_q;
  assign RX_ER         = rx_er_q;
  assign RXD           = rxd_q;
  assign carrier_sense = cs_q;
  assign frames_ok     = ok_q;
  assign frames_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pcs_receive_gmii.sv
// tb_pcs_receive_gmii: scoreboard bench; dut_a uses ERR_ON_CODE_ERR=1, dut_b uses 0 with 2-bit counters.
// Revision 1.0 - initial release.
`default_nettype none

module tb_pcs_receive_gmii;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync_status;
  logic       sudi_valid;
  logic       sudi_k;
  logic [7:0] sudi_data;
  logic       sudi_err;

  logic        a_dv, a_er, a_cs, b_dv, b_er, b_cs;
  logic [7:0]  a_rxd, b_rxd;
  logic [15:0] a_ok, a_errc;
  logic [1:0]  b_ok, b_errc;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    string      tag;
    int         due;
    logic       dv, er, erb;
    logic [7:0] rxd;
    logic       cs, mr, mc;
  } exp_t;

  exp_t sb[$];

  pcs_receive_gmii #(.MAX_FRAME_BYTES(64), .CNT_W(16), .ERR_ON_CODE_ERR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .sync_status(sync_status), .sudi_valid(sudi_valid),
    .sudi_k(sudi_k), .sudi_data(sudi_data), .sudi_err(sudi_err),
    .RX_DV(a_dv), .RX_ER(a_er), .RXD(a_rxd), .carrier_sense(a_cs),
    .frames_ok(a_ok), .frames_err(a_errc)
  );

  pcs_receive_gmii #(.MAX_FRAME_BYTES(64), .CNT_W(2), .ERR_ON_CODE_ERR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sync_status(sync_status), .sudi_valid(sudi_valid),
    .sudi_k(sudi_k), .sudi_data(sudi_data), .sudi_err(sudi_err),
    .RX_DV(b_dv), .RX_ER(b_er), .RXD(b_rxd), .carrier_sense(b_cs),
    .frames_ok(b_ok), .frames_err(b_errc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.tag, ".a_dv"}, 32'(a_dv), 32'(e.dv));
      check({e.tag, ".a_er"}, 32'(a_er), 32'(e.er));
      check({e.tag, ".b_dv"}, 32'(b_dv), 32'(e.dv));
      check({e.tag, ".b_er"}, 32'(b_er), 32'(e.erb));
      if (e.mr) begin
        check({e.tag, ".a_rxd"}, 32'(a_rxd), 32'(e.rxd));
        check({e.tag, ".b_rxd"}, 32'(b_rxd), 32'(e.rxd));
      end
      if (e.mc) begin
        check({e.tag, ".a_cs"}, 32'(a_cs), 32'(e.cs));
        check({e.tag, ".b_cs"}, 32'(b_cs), 32'(e.cs));
      end
    end
  end

  // Drive one code-group and queue the outputs expected one cycle later.
  task automatic send(input string tag, input logic s, input logic k, input logic [7:0] d,
                      input logic e, input logic dv, input logic er, input logic erb,
                      input logic [7:0] rxd, input logic cs, input logic mr, input logic mc);
    exp_t x;
    @(negedge clk);
    sync_status = s;
    sudi_valid  = 1'b1;
    sudi_k      = k;
    sudi_data   = d;
    sudi_err    = e;
    x.tag = tag; x.due = cyc + 1; x.dv = dv; x.er = er; x.erb = erb;
    x.rxd = rxd; x.cs = cs; x.mr = mr; x.mc = mc;
    sb.push_back(x);
  endtask

  task automatic quiet();
    @(negedge clk);
    sudi_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      send("idle_k", 1, 1, 8'hBC, 0, 0, 0, 0, 8'h00, 0, 1, 1);
      send("idle_d", 1, 0, 8'h50, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    end
  endtask

  task automatic frame(input int n, input logic [7:0] base);
    logic [7:0] v;
    send("sfd", 1, 1, 8'hFB, 0, 1, 0, 0, 8'h55, 1, 1, 1);
    for (int i = 0; i < n; i++) begin
      v = base + 8'(i);
      send($sformatf("byte%0d", i + 1), 1, 0, v, 0, 1, 0, 0, v, 1, 1, 1);
    end
  endtask

  task automatic end_frame();
    send("T", 1, 1, 8'hFD, 0, 0, 0, 0, 8'h0F, 0, 1, 0);
    send("R", 1, 1, 8'hF7, 0, 0, 0, 0, 8'h0F, 0, 1, 1);
  endtask

  task automatic counters(input string tag, input int aok, input int aerr, input int bok, input int berr);
    quiet();
    check({tag, ".a_ok"},  32'(a_ok),   aok);
    check({tag, ".a_err"}, 32'(a_errc), aerr);
    check({tag, ".b_ok"},  32'(b_ok),   bok);
    check({tag, ".b_err"}, 32'(b_errc), berr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sync_status = 1'b0; sudi_valid = 1'b0;
    sudi_k = 1'b0; sudi_data = 8'h00; sudi_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.dv", 32'(a_dv), 0);
    check("rst.er", 32'(a_er), 0);
    check("rst.rxd", 32'(a_rxd), 0);
    check("rst.cs", 32'(a_cs), 0);
    reset = 1'b0;
    counters("rst", 0, 0, 0, 0);

    // Clean 64-byte frame exactly at the jabber limit.
    idle(4);
    frame(64, 8'h01);
    end_frame();
    counters("good", 1, 0, 1, 0);

    // False carrier from a data group in IDLE_D.
    idle(4);
    send("fc0", 1, 0, 8'hAA, 0, 0, 1, 1, 8'h0E, 1, 1, 1);
    send("fc1", 1, 0, 8'h12, 0, 0, 1, 1, 8'h0E, 1, 1, 1);
    send("fc_end", 1, 1, 8'hBC, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    counters("fc", 1, 0, 1, 0);

    // Early end: K28.5 replaces /T/, then a normal frame.
    idle(4);
    frame(10, 8'h20);
    send("early", 1, 1, 8'hBC, 0, 1, 1, 1, 8'h00, 0, 0, 1);
    counters("early", 1, 1, 1, 1);
    idle(4);
    frame(5, 8'h30);
    end_frame();
    counters("after_early", 2, 1, 2, 1);

    // /V/ and a code error inside a frame.
    idle(4);
    frame(3, 8'h40);
    send("V", 1, 1, 8'hFE, 0, 1, 1, 1, 8'h00, 1, 1, 1);
    send("d", 1, 0, 8'h44, 0, 1, 0, 0, 8'h44, 1, 1, 1);
    send("cerr", 1, 0, 8'h33, 1, 1, 1, 0, 8'h33, 1, 1, 1);
    send("K_as_V", 1, 1, 8'hF7, 0, 1, 1, 1, 8'h00, 1, 1, 1);
    send("d2", 1, 0, 8'h45, 0, 1, 0, 0, 8'h45, 1, 1, 1);
    end_frame();
    counters("verr", 3, 1, 3, 1);

    // Jabber: 70 data bytes with a 64-byte limit.
    idle(4);
    frame(64, 8'h80);
    send("jab", 1, 0, 8'hC0, 0, 1, 1, 1, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      send("jab_hold", 1, 0, 8'hC1 + 8'(i), 0, 0, 0, 0, 8'h00, 0, 1, 1);
    send("jab_end", 1, 1, 8'hBC, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    counters("jabber", 3, 2, 3, 2);

    // Sync loss at byte 5.
    idle(4);
    frame(4, 8'h01);
    send("sync_loss", 0, 0, 8'h05, 0, 1, 1, 1, 8'h00, 0, 1, 1);
    send("sync_off", 0, 0, 8'h06, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    send("sync_off2", 0, 1, 8'hBC, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    counters("sync", 3, 3, 3, 3);

    // Recovery; dut_b's 2-bit frames_ok saturates at 3.
    idle(4);
    frame(8, 8'h10);
    end_frame();
    counters("sat", 4, 3, 3, 3);

    // Reset mid-frame clears everything on the next cycle.
    idle(4);
    frame(3, 8'h50);
    @(negedge clk);
    reset = 1'b1; sudi_valid = 1'b1; sudi_k = 1'b0; sudi_data = 8'h09; sudi_err = 1'b0;
    @(negedge clk);
    check("mrst.dv", 32'(a_dv), 0);
    check("mrst.er", 32'(a_er), 0);
    check("mrst.rxd", 32'(a_rxd), 0);
    check("mrst.cs", 32'(a_cs), 0);
    check("mrst.a_ok", 32'(a_ok), 0);
    check("mrst.a_err", 32'(a_errc), 0);
    check("mrst.b_ok", 32'(b_ok), 0);
    check("mrst.b_err", 32'(b_errc), 0);
    reset = 1'b0;
    sudi_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
